// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the memory port and mem_arbiter.
// The arbiter connects through the slave modport; the requester/memory side connects through master.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic        busy;

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    input  mem_ready, mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output busy
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    output mem_ready, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single memory port, one access in flight.
// Optional fetch starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
//
// state | meaning
// IDLE  | no access in flight; arbitrate and grant one requester
// FETCH | fetch access on memory port, waiting for mem_ready
// DATA  | load/store access on memory port, waiting for mem_ready
module mem_arbiter (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;

  logic        if_rvalid_q, if_rvalid_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic        dm_rvalid_q, dm_rvalid_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;

  logic        if_gnt;
  logic        dm_gnt;
  logic        fetch_first;
  logic        active;

`ifdef MEM_ARB_STARVE_GUARD_EN
  // Counts data grants that overtook a waiting fetch; at 4 the fetch wins once.
  logic [2:0] starve_q, starve_d;

  assign fetch_first = (starve_q == 3'd4);

  always_comb begin
    starve_d = starve_q;
    if (if_gnt) begin
      starve_d = 3'd0;
    end else if (dm_gnt && bus.if_req && (starve_q != 3'd7)) begin
      starve_d = starve_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= 3'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign fetch_first = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    be_d        = be_q;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_gnt      = 1'b0;
    dm_gnt      = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rst) begin
          if (bus.dm_req && !(fetch_first && bus.if_req)) begin
            dm_gnt  = 1'b1;
            state_d = DATA;
            addr_d  = bus.dm_addr;
            wdata_d = bus.dm_wdata;
            we_d    = bus.dm_we;
            be_d    = bus.dm_we ? bus.dm_be : 4'hF;
          end else if (bus.if_req) begin
            if_gnt  = 1'b1;
            state_d = FETCH;
            addr_d  = bus.if_addr;
            wdata_d = 32'h0;
            we_d    = 1'b0;
            be_d    = 4'hF;
          end
        end
      end
      FETCH: begin
        if (bus.mem_ready) begin
          if_rvalid_d = 1'b1;
          if_rdata_d  = bus.mem_rdata;
          state_d     = IDLE;
        end
      end
      DATA: begin
        if (bus.mem_ready) begin
          dm_rvalid_d = 1'b1;
          dm_rdata_d  = we_q ? 32'h0 : bus.mem_rdata;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      we_q        <= 1'b0;
      be_q        <= 4'h0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= 32'h0;
      dm_rvalid_q <= 1'b0;
      dm_rdata_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      be_q        <= be_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rvalid_q <= dm_rvalid_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  // Outputs are forced low for the whole reset cycle, not just after the edge.
  assign active        = (state_q != IDLE) && !rst;

  assign bus.if_gnt    = if_gnt;
  assign bus.dm_gnt    = dm_gnt;
  assign bus.mem_req   = active;
  assign bus.mem_we    = active && we_q;
  assign bus.mem_addr  = active ? addr_q  : 32'h0;
  assign bus.mem_wdata = active ? wdata_q : 32'h0;
  assign bus.mem_be    = active ? be_q    : 4'h0;
  assign bus.busy      = active;

  assign bus.if_rvalid = if_rvalid_q && !rst;
  assign bus.if_rdata  = rst ? 32'h0 : if_rdata_q;
  assign bus.dm_rvalid = dm_rvalid_q && !rst;
  assign bus.dm_rdata  = rst ? 32'h0 : dm_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios then randomized traffic,
// every output compared each cycle against a transaction-level reference model.
module tb_mem_arbiter;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: which port owns the memory, and what it asked for.
  int          m_own = 0;   // 0 none, 1 fetch, 2 data
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic        m_we = 1'b0;
  logic [3:0]  m_be = '0;
  logic        m_if_rv = 1'b0, m_dm_rv = 1'b0;
  logic [31:0] m_if_rd = '0, m_dm_rd = '0;
  int          m_starve = 0;
  logic        e_if_gnt = 1'b0, e_dm_gnt = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic sample();
    logic on;
    logic ff;
    logic own;
    @(negedge clk);
    on  = !rst;
    ff  = GUARD && (m_starve == 4);
    own = on && (m_own != 0);
    e_dm_gnt = on && (m_own == 0) && bus.dm_req && !(ff && bus.if_req);
    e_if_gnt = on && (m_own == 0) && bus.if_req && !e_dm_gnt;
    chk("if_gnt",    32'(bus.if_gnt),    32'(e_if_gnt));
    chk("dm_gnt",    32'(bus.dm_gnt),    32'(e_dm_gnt));
    chk("mem_req",   32'(bus.mem_req),   32'(own));
    chk("mem_we",    32'(bus.mem_we),    32'(own && m_own == 2 && m_we));
    chk("mem_addr",  bus.mem_addr,       own ? m_addr : 32'h0);
    chk("mem_wdata", bus.mem_wdata,      own ? m_wdata : 32'h0);
    chk("mem_be",    32'(bus.mem_be),    own ? 32'(m_be) : 32'h0);
    chk("busy",      32'(bus.busy),      32'(own));
    chk("if_rvalid", 32'(bus.if_rvalid), 32'(on && m_if_rv));
    chk("if_rdata",  bus.if_rdata,       on ? m_if_rd : 32'h0);
    chk("dm_rvalid", 32'(bus.dm_rvalid), 32'(on && m_dm_rv));
    chk("dm_rdata",  bus.dm_rdata,       on ? m_dm_rd : 32'h0);
  endtask

  task automatic adv();
    @(posedge clk);
    if (rst) begin
      m_own = 0; m_addr = '0; m_wdata = '0; m_we = 1'b0; m_be = '0;
      m_if_rv = 1'b0; m_dm_rv = 1'b0; m_if_rd = '0; m_dm_rd = '0; m_starve = 0;
    end else begin
      m_if_rv = 1'b0;
      m_dm_rv = 1'b0;
      if (m_own == 1 && bus.mem_ready) begin
        m_if_rv = 1'b1; m_if_rd = bus.mem_rdata; m_own = 0;
      end else if (m_own == 2 && bus.mem_ready) begin
        m_dm_rv = 1'b1; m_dm_rd = m_we ? 32'h0 : bus.mem_rdata; m_own = 0;
      end else if (m_own == 0 && e_dm_gnt) begin
        m_own = 2; m_addr = bus.dm_addr; m_wdata = bus.dm_wdata; m_we = bus.dm_we;
        m_be = bus.dm_we ? bus.dm_be : 4'hF;
        if (bus.if_req) m_starve++;
      end else if (m_own == 0 && e_if_gnt) begin
        m_own = 1; m_addr = bus.if_addr; m_wdata = 32'h0; m_we = 1'b0; m_be = 4'hF;
        m_starve = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0; bus.dm_be = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    sample(); adv();
    rst = 1'b0;
  endtask

  int dm_at, if_at, n_dm;

  initial begin
    do_reset();
    do_reset();

    // Reset state
    sample();
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_dm_rdata", bus.dm_rdata, 32'h0);
    adv();

    // Lone fetch
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    sample(); chk("lf_gnt", 32'(bus.if_gnt), 32'h1); adv();
    bus.if_req = 1'b0; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h00500093;
    sample();
    chk("lf_addr", bus.mem_addr, 32'h100);
    chk("lf_be", 32'(bus.mem_be), 32'hF);
    adv();
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    sample();
    chk("lf_rvalid", 32'(bus.if_rvalid), 32'h1);
    chk("lf_rdata", bus.if_rdata, 32'h00500093);
    adv();

    // Store with three wait cycles
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h2000;
    bus.dm_wdata = 32'hDEADBEEF; bus.dm_be = 4'b0011;
    sample(); chk("st_gnt", 32'(bus.dm_gnt), 32'h1); adv();
    bus.dm_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = (i == 3);
      sample(); chk("st_we_held", 32'(bus.mem_we), 32'h1); adv();
    end
    bus.mem_ready = 1'b0;
    sample();
    chk("st_rvalid", 32'(bus.dm_rvalid), 32'h1);
    chk("st_rdata", bus.dm_rdata, 32'h0);
    chk("st_busy", 32'(bus.busy), 32'h0);
    chk("st_we_end", 32'(bus.mem_we), 32'h0);
    adv();

    // Contention
    bus.if_req = 1'b1; bus.if_addr = 32'h300;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h400;
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h11111111;
    dm_at = -1; if_at = -1;
    for (int c = 0; c < 12 && if_at < 0; c++) begin
      sample();
      chk("ct_both", 32'(bus.if_gnt & bus.dm_gnt), 32'h0);
      if (bus.dm_gnt && dm_at < 0) dm_at = c;
      if (bus.if_gnt) if_at = c;
      adv();
      if (e_dm_gnt) bus.dm_req = 1'b0;
      if (e_if_gnt) bus.if_req = 1'b0;
    end
    chk("ct_dm_first", 32'(dm_at), 32'h0);
    chk("ct_if_at", 32'(if_at), 32'h2);
    repeat (2) begin sample(); adv(); end

    // Starvation: fetch held, data re-asserted continuously
    do_reset();
    bus.if_req = 1'b1; bus.if_addr = 32'h500;
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h600;
    bus.dm_wdata = 32'h1; bus.dm_be = 4'hF; bus.mem_ready = 1'b1;
    n_dm = 0; if_at = -1;
    for (int c = 0; c < 14; c++) begin
      sample();
      if (if_at < 0) begin
        if (bus.dm_gnt) n_dm++;
        if (bus.if_gnt) if_at = c;
      end
      adv();
      if (e_if_gnt) bus.if_req = 1'b0;
    end
    chk("sv_n_dm", 32'(n_dm), GUARD ? 32'd4 : 32'd7);
    chk("sv_if_at", 32'(if_at), GUARD ? 32'd8 : 32'hFFFFFFFF);

    // Reset in the middle of a data access
    do_reset();
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h700;
    sample(); adv();
    bus.dm_req = 1'b0;
    sample(); chk("rm_busy_pre", 32'(bus.busy), 32'h1); adv();
    rst = 1'b1;
    sample();
    chk("rm_busy", 32'(bus.busy), 32'h0);
    chk("rm_mem_req", 32'(bus.mem_req), 32'h0);
    adv();
    rst = 1'b0; bus.mem_ready = 1'b1; bus.mem_rdata = 32'hAAAA5555;
    sample(); chk("rm_rvalid0", 32'(bus.dm_rvalid), 32'h0); adv();
    bus.mem_ready = 1'b0;
    sample();
    chk("rm_rvalid1", 32'(bus.dm_rvalid), 32'h0);
    chk("rm_busy_post", 32'(bus.busy), 32'h0);
    adv();

    // Back-to-back loads
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h800;
    sample(); chk("bb_gnt0", 32'(bus.dm_gnt), 32'h1); adv();
    bus.dm_req = 1'b0; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h12345678;
    sample(); adv();
    bus.dm_req = 1'b1; bus.dm_addr = 32'h804; bus.mem_ready = 1'b0;
    sample();
    chk("bb_rv2", 32'(bus.dm_rvalid), 32'h1);
    chk("bb_rd2", bus.dm_rdata, 32'h12345678);
    chk("bb_gnt2", 32'(bus.dm_gnt), 32'h1);
    adv();
    bus.dm_req = 1'b0; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h9ABCDEF0;
    sample();
    chk("bb_rv3", 32'(bus.dm_rvalid), 32'h0);
    chk("bb_rd3_hold", bus.dm_rdata, 32'h12345678);
    adv();
    bus.mem_ready = 1'b0;
    sample();
    chk("bb_rv4", 32'(bus.dm_rvalid), 32'h1);
    chk("bb_rd4", bus.dm_rdata, 32'h9ABCDEF0);
    adv();

    // Randomized traffic; requesters hold their fields until granted
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      sample();
      adv();
      if (!bus.if_req || e_if_gnt) begin
        bus.if_req  = ($urandom_range(0, 2) != 0);
        bus.if_addr = $urandom;
      end
      if (!bus.dm_req || e_dm_gnt) begin
        bus.dm_req   = ($urandom_range(0, 2) != 0);
        bus.dm_we    = ($urandom_range(0, 1) != 0);
        bus.dm_addr  = $urandom;
        bus.dm_wdata = $urandom;
        bus.dm_be    = 4'($urandom);
      end
      bus.mem_ready = ($urandom_range(0, 2) != 0);
      bus.mem_rdata = $urandom;
      rst = ($urandom_range(0, 149) == 0);
    end
    rst = 1'b0;
    sample();
    adv();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
